// File: rtl/pla_bist_sweep_ctrl.sv
// pla_bist_sweep_ctrl: sweeps a PLA input range and compresses the PLA outputs into a MISR signature
module pla_bist_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] SEED = 16'hFFFF,
  parameter logic [15:0] POLY = 16'h1021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [13:0] lo,
  input  logic [13:0] hi,
  output logic [13:0] pla_in,
  input  logic [13:0] pla_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        aborted,
  output logic [15:0] signature,
  output logic [14:0] vec_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [13:0] hi_q;
  logic [3:0] cnt;
  logic sample;
  logic [15:0] sig_next;
  assign sample = cnt == 4'(SETTLE);
  assign sig_next = {signature[14:0], 1'b0} ^ (signature[15] ? POLY : 16'h0) ^ {2'b00, pla_out};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi_q <= '0;
      cnt <= '0;
      pla_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      aborted <= 1'b0;
      signature <= SEED;
      vec_count <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort && lo <= hi) begin
            state <= RUN;
            hi_q <= hi;
            pla_in <= lo;
            signature <= SEED;
            vec_count <= '0;
            aborted <= 1'b0;
            cnt <= '0;
            busy <= 1'b1;
          end else if (start && lo > hi) begin
            err <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy <= 1'b0;
            aborted <= 1'b1;
          end else if (sample) begin
            signature <= sig_next;
            vec_count <= vec_count + 15'd1;
            cnt <= '0;
            // terminate before incrementing so hi = 3FFF never wraps
            if (pla_in == hi_q) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              pla_in <= pla_in + 14'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
